// File: rtl/ram_write_buffer.sv
// Posted-write buffer between the cache eviction port and the RAM write port.
// It drains in allocation order, merges writes to a pending word, and forwards
// pending data combinationally to the memory stage.
module ram_write_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_we,
    input  logic [DATA_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_wd,
    output logic                  full,
    output logic                  empty,
    input  logic                  drain_en,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wd,
    input  logic [DATA_WIDTH-1:0] r_addr,
    output logic                  fwd_hit,
    output logic [DATA_WIDTH-1:0] fwd_data
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned WA_W  = DATA_WIDTH - 2;

    logic [DEPTH-1:0]      valid_q;
    logic [WA_W-1:0]       waddr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q  [DEPTH];
    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      tail_q;
    logic [CNT_W-1:0]      count_q;
    logic                  full_q;
    logic                  empty_q;

    logic [WA_W-1:0]       in_waddr;
    logic [WA_W-1:0]       r_waddr;
    logic                  pop;
    logic [DEPTH-1:0]      merge_vec;
    logic                  merge_any;
    logic                  merge_hit;
    logic                  alloc;
    logic [CNT_W-1:0]      count_next;
    logic                  unused_lsbs;

    // Byte-offset bits play no part in word matching
    assign in_waddr    = in_addr[DATA_WIDTH-1:2];
    assign r_waddr     = r_addr[DATA_WIDTH-1:2];
    assign unused_lsbs = ^{in_addr[1:0], r_addr[1:0]};

    // Pop whenever RAM port is free and something is pending
    assign pop = drain_en && !empty_q;

    // Merge candidates: pending entries with the same word, except the one leaving now
    always_comb begin
        merge_vec = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (waddr_q[i] == in_waddr) &&
                !(pop && (head_q == PTR_W'(i)))) begin
                merge_vec[i] = 1'b1;
            end
        end
    end

    assign merge_any  = |merge_vec;
    assign merge_hit  = in_we && merge_any;
    // Slot freed by a same-cycle pop is not reused until the next cycle
    assign alloc      = in_we && !merge_any && (count_q < CNT_W'(DEPTH));
    assign count_next = count_q + CNT_W'(alloc) - CNT_W'(pop);

    // Head entry presented to RAM, zero when nothing is pending
    assign ram_we   = pop;
    assign ram_addr = empty_q ? '0 : {waddr_q[head_q], 2'b00};
    assign ram_wd   = empty_q ? '0 : data_q[head_q];
    assign full     = full_q;
    assign empty    = empty_q;

    // Forwarding: at most one valid entry can hold a given word
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (waddr_q[i] == r_waddr)) begin
                fwd_hit  = 1'b1;
                fwd_data = fwd_data | data_q[i];
            end
        end
    end

    // Entry storage, pointers, count and registered flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                waddr_q[i] <= '0;
                data_q[i]  <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            if (merge_hit) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (merge_vec[i]) begin
                        data_q[i] <= in_wd;
                    end
                end
            end
            if (alloc) begin
                valid_q[tail_q] <= 1'b1;
                waddr_q[tail_q] <= in_waddr;
                data_q[tail_q]  <= in_wd;
                tail_q          <= tail_q + PTR_W'(1);
            end
            count_q <= count_next;
            full_q  <= (count_next == CNT_W'(DEPTH));
            empty_q <= (count_next == '0);
        end
    end

endmodule

// File: tb/tb_ram_write_buffer.sv
// Scoreboard bench for ram_write_buffer: directed pushes queue the expected
// RAM writes; a monitor compares every asserted ram_we against the queue.
module tb_ram_write_buffer;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_we;
    logic [31:0] in_addr;
    logic [31:0] in_wd;
    logic        full;
    logic        empty;
    logic        drain_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wd;
    logic [31:0] r_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    int  n_tests = 0;
    int  n_fail  = 0;
    wr_t exp_q[$];

    ram_write_buffer #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_we    (in_we),
        .in_addr  (in_addr),
        .in_wd    (in_wd),
        .full     (full),
        .empty    (empty),
        .drain_en (drain_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wd   (ram_wd),
        .r_addr   (r_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic dr);
        in_we    = we;
        in_addr  = a;
        in_wd    = d;
        drain_en = dr;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every RAM write must match the oldest outstanding expectation
    always @(negedge clk) begin
        wr_t e;
        if (rst === 1'b0 && ram_we === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ram_write: got addr %h data %h expected none",
                         ram_addr, ram_wd);
            end else begin
                e = exp_q.pop_front();
                if (ram_addr !== e.addr || ram_wd !== e.data) begin
                    n_fail++;
                    $display("FAIL ram_write: got addr %h data %h expected addr %h data %h",
                             ram_addr, ram_wd, e.addr, e.data);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_we = 1'b0; in_addr = '0; in_wd = '0; drain_en = 1'b0; r_addr = '0;
        #1;
        // Reset then idle
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_fwd_hit", fwd_hit, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("idle_ram_we", ram_we, 0);
        check("idle_empty", empty, 1);

        // Fill and drain
        for (int i = 0; i < 4; i++) begin
            expect_wr(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
            step(1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 0);
            if (i == 2) check("fill3_full", full, 0);
        end
        check("fill4_full", full, 1);
        check("fill4_empty", empty, 0);
        check("fill4_head_addr", ram_addr, 32'h100);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        check("drain_empty", empty, 1);
        check("drain_full", full, 0);
        check("drain_sb", 32'(exp_q.size()), 0);

        // Merge when full
        for (int i = 0; i < 4; i++) begin
            expect_wr(32'h100 + 32'(4 * i), (i == 1) ? 32'hBEEF : 32'hA0 + 32'(i));
            step(1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 0);
        end
        step(1, 32'h106, 32'hBEEF, 0);
        check("merge_full", full, 1);
        r_addr = 32'h104;
        #1;
        check("merge_fwd", fwd_data, 32'hBEEF);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        check("merge_empty", empty, 1);
        check("merge_sb", 32'(exp_q.size()), 0);

        // Forwarding
        in_we = 1'b1; in_addr = 32'h200; in_wd = 32'h1234; drain_en = 1'b0; r_addr = 32'h202;
        expect_wr(32'h200, 32'h1234);
        #1;
        check("fwd_same_cycle_hit", fwd_hit, 0);
        @(posedge clk); #1;
        in_we = 1'b0;
        #1;
        check("fwd_hit", fwd_hit, 1);
        check("fwd_data", fwd_data, 32'h1234);
        r_addr = 32'h204;
        #1;
        check("fwd_miss_hit", fwd_hit, 0);
        check("fwd_miss_data", fwd_data, 0);
        r_addr = 32'h202; drain_en = 1'b1;
        #1;
        check("fwd_during_pop", fwd_hit, 1);
        @(posedge clk); #1;
        check("fwd_after_pop", fwd_hit, 0);

        // Push to head during pop
        expect_wr(32'h300, 32'h11);
        step(1, 32'h300, 32'h11, 0);
        expect_wr(32'h300, 32'h22);
        step(1, 32'h300, 32'h22, 1);
        check("headpush_empty", empty, 0);
        step(0, 0, 0, 1);
        check("headpush_drained", empty, 1);
        check("headpush_sb", 32'(exp_q.size()), 0);

        // Byte offset bits are cleared on the RAM address
        expect_wr(32'h308, 32'h55);
        step(1, 32'h30B, 32'h55, 0);
        check("lsb_ram_addr", ram_addr, 32'h308);
        step(0, 0, 0, 1);
        check("empty_ram_addr", ram_addr, 0);
        check("empty_ram_wd", ram_wd, 0);

        // Async reset with three entries pending
        for (int i = 0; i < 3; i++) step(1, 32'h400 + 32'(4 * i), 32'(i + 1), 0);
        in_we = 1'b0; drain_en = 1'b1; r_addr = 32'h400;
        #1;
        check("prereset_ram_we", ram_we, 1);
        check("prereset_fwd", fwd_hit, 1);
        #1;
        rst = 1'b1;
        #1;
        check("areset_ram_we", ram_we, 0);
        check("areset_empty", empty, 1);
        check("areset_fwd", fwd_hit, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        check("postreset_empty", empty, 1);
        check("postreset_ram_we", ram_we, 0);
        check("final_sb", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
